// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter: in-order pipe results take priority,
// multi-cycle results queue in a FIFO with a forced drain after a stall budget.
module regfile_writeback_arbiter #(
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipeValid,
    input  logic [4:0]               pipeAddress,
    input  logic [31:0]              pipeData,
    output logic                     stallPipe,
    input  logic                     mcValid,
    output logic                     mcReady,
    input  logic [4:0]               mcAddress,
    input  logic [31:0]              mcData,
    output logic                     writeRegister,
    output logic [4:0]               writeAddress,
    output logic [31:0]              writeData,
    output logic [$clog2(DEPTH):0]   fifoCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(MAX_STALL);

    logic [4:0]    r_addr_q [DEPTH];
    logic [31:0]   r_data_q [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_scnt;
    logic          r_stall;
    logic          r_wen;
    logic [4:0]    r_waddr;
    logic [31:0]   r_wdata;

    logic          w_nonempty;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_sel;
    logic          w_sel;
    logic [4:0]    w_sel_addr;
    logic [31:0]   w_sel_data;
    logic [SW-1:0] w_scnt_nxt;
    logic          w_stall_set;

    always_comb begin
        w_nonempty = (r_count != '0);
        mcReady    = (r_count != FULL);
        w_push     = mcValid && mcReady;
        // During a forced stall the pipe input is ignored outright
        w_pop      = w_nonempty && (r_stall || !pipeValid);
        w_pipe_sel = pipeValid && !r_stall;
        w_sel      = w_pop || w_pipe_sel;
        w_sel_addr = w_pop ? r_addr_q[r_rptr] : pipeAddress;
        w_sel_data = w_pop ? r_data_q[r_rptr] : pipeData;
        w_scnt_nxt = r_scnt;
        if (w_pop || !w_nonempty) begin
            w_scnt_nxt = '0;
        end else if (w_pipe_sel) begin
            w_scnt_nxt = r_scnt + 1'b1;
        end
        w_stall_set = !r_stall && (w_scnt_nxt == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wptr] <= mcAddress;
            r_data_q[r_wptr] <= mcData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_scnt  <= '0;
            r_stall <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_stall <= w_stall_set;
            r_scnt  <= w_stall_set ? '0 : w_scnt_nxt;
            // x0 results are consumed but never written
            r_wen   <= w_sel && (w_sel_addr != 5'd0);
            if (w_sel) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign stallPipe     = r_stall;
    assign writeRegister = r_wen;
    assign writeAddress  = r_waddr;
    assign writeData     = r_wdata;
    assign fifoCount     = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for the register-file writeback arbiter.
// Checks reset, pipe writes, FIFO fill/drain order, forced stall and x0 handling.
module tb_regfile_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        pipeValid;
    logic [4:0]  pipeAddress;
    logic [31:0] pipeData;
    logic        stallPipe;
    logic        mcValid;
    logic        mcReady;
    logic [4:0]  mcAddress;
    logic [31:0] mcData;
    logic        writeRegister;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [2:0]  fifoCount;

    int total;
    int bad;

    regfile_writeback_arbiter #(.DEPTH(4), .MAX_STALL(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pipeValid     (pipeValid),
        .pipeAddress   (pipeAddress),
        .pipeData      (pipeData),
        .stallPipe     (stallPipe),
        .mcValid       (mcValid),
        .mcReady       (mcReady),
        .mcAddress     (mcAddress),
        .mcData        (mcData),
        .writeRegister (writeRegister),
        .writeAddress  (writeAddress),
        .writeData     (writeData),
        .fifoCount     (fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipeValid   = 1'b0;
        pipeAddress = 5'd0;
        pipeData    = 32'd0;
        mcValid     = 1'b0;
        mcAddress   = 5'd0;
        mcData      = 32'd0;
    endtask

    initial begin
        int k;
        logic seen;
        total = 0;
        bad   = 0;

        // reset with active inputs
        reset       = 1'b1;
        pipeValid   = 1'b1;
        pipeAddress = 5'd12;
        pipeData    = 32'h5555_5555;
        mcValid     = 1'b1;
        mcAddress   = 5'd13;
        mcData      = 32'h6666_6666;
        step();
        step();
        chk("rst_wen", 32'(writeRegister), 32'd0);
        chk("rst_stall", 32'(stallPipe), 32'd0);
        chk("rst_count", 32'(fifoCount), 32'd0);
        chk("rst_addr", 32'(writeAddress), 32'd0);
        chk("rst_data", writeData, 32'd0);
        idle();
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(mcReady), 32'd1);
        step();

        // single pipe write
        pipeValid   = 1'b1;
        pipeAddress = 5'd5;
        pipeData    = 32'hDEAD_BEEF;
        step();
        idle();
        chk("pipe_wen", 32'(writeRegister), 32'd1);
        chk("pipe_addr", 32'(writeAddress), 32'd5);
        chk("pipe_data", writeData, 32'hDEAD_BEEF);
        step();
        chk("pipe_idle_wen", 32'(writeRegister), 32'd0);
        chk("pipe_hold_addr", 32'(writeAddress), 32'd5);
        chk("pipe_hold_data", writeData, 32'hDEAD_BEEF);

        // fill FIFO while pipe is busy writing x0
        for (int i = 0; i < 4; i++) begin
            pipeValid   = 1'b1;
            pipeAddress = 5'd0;
            pipeData    = 32'h0BAD_0000;
            mcValid     = 1'b1;
            mcAddress   = 5'(3 + i);
            mcData      = 32'hA000_0000 + 32'(i);
            step();
            chk("fill_wen", 32'(writeRegister), 32'd0);
        end
        mcAddress = 5'd7;
        mcData    = 32'hA000_0007;
        #1;
        chk("full_ready", 32'(mcReady), 32'd0);
        chk("full_count", 32'(fifoCount), 32'd4);
        step();
        chk("full_hold", 32'(fifoCount), 32'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_wen", 32'(writeRegister), 32'd1);
            chk("drain_addr", 32'(writeAddress), 32'(3 + i));
            chk("drain_data", writeData, 32'hA000_0000 + 32'(i));
        end
        chk("drain_count", 32'(fifoCount), 32'd0);
        step();
        chk("drain_nowrite", 32'(writeRegister), 32'd0);

        // anti-starvation: pipe held high with one FIFO entry
        pipeValid   = 1'b1;
        pipeAddress = 5'd7;
        pipeData    = 32'h0000_0077;
        mcValid     = 1'b1;
        mcAddress   = 5'd9;
        mcData      = 32'h0000_0099;
        step();
        mcValid = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (stallPipe) begin
                k = i;
                break;
            end
            chk("starve_wen", 32'(writeRegister), 32'd1);
            chk("starve_addr", 32'(writeAddress), 32'd7);
        end
        chk("stall_cycles", 32'(k), 32'd8);
        chk("stall_count", 32'(fifoCount), 32'd1);
        step();
        chk("stall_width", 32'(stallPipe), 32'd0);
        chk("stall_pop_addr", 32'(writeAddress), 32'd9);
        chk("stall_pop_data", writeData, 32'h0000_0099);
        chk("stall_pop_wen", 32'(writeRegister), 32'd1);
        step();
        chk("resume_addr", 32'(writeAddress), 32'd7);
        chk("resume_count", 32'(fifoCount), 32'd0);
        idle();
        step();

        // x0 from both sources
        pipeValid   = 1'b1;
        pipeAddress = 5'd0;
        pipeData    = 32'h0000_1234;
        mcValid     = 1'b1;
        mcAddress   = 5'd0;
        mcData      = 32'h0000_4321;
        step();
        idle();
        seen = writeRegister;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | writeRegister;
        end
        chk("x0_nowrite", 32'(seen), 32'd0);
        chk("x0_consumed", 32'(fifoCount), 32'd0);

        // reset mid-operation discards FIFO contents
        for (int i = 0; i < 3; i++) begin
            pipeValid   = 1'b1;
            pipeAddress = 5'd0;
            mcValid     = 1'b1;
            mcAddress   = 5'(20 + i);
            mcData      = 32'hC000_0000 + 32'(i);
            step();
        end
        idle();
        chk("pre_rst_count", 32'(fifoCount), 32'd3);
        reset = 1'b1;
        #2;
        chk("mid_rst_count", 32'(fifoCount), 32'd0);
        chk("mid_rst_wen", 32'(writeRegister), 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | writeRegister;
        end
        chk("post_rst_nowrite", 32'(seen), 32'd0);
        chk("post_rst_ready", 32'(mcReady), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
